// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by every pipeline stage.
package cpu_types_pkg;
  localparam int WORD_BITS = 32;
  typedef logic [WORD_BITS-1:0] word_t;
endpackage

// File: rtl/my_types_pkg.sv
// Fetch-stage types: FSM encoding, the IF/ID entry record and the default reset PC.
package my_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    FS_RUN  = 2'd0,
    FS_SKID = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } fetch_entry_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if.sv
// Icache, hazard/redirect and IF/ID signals of the fetch stage, viewed from the block (fs) or the bench (tb).
interface fetch_stage_if;
  logic                 ihit;
  cpu_types_pkg::word_t iload;
  logic                 imemREN;
  cpu_types_pkg::word_t imemaddr;
  logic                 stall;
  logic                 redirect_en;
  cpu_types_pkg::word_t redirect_pc;
  logic                 halt_in;
  cpu_types_pkg::word_t instr_out;
  cpu_types_pkg::word_t pc_out;
  cpu_types_pkg::word_t npc_out;
  logic                 valid_out;
  logic                 halted;

  modport fs (
    input  ihit, iload, stall, redirect_en, redirect_pc, halt_in,
    output imemREN, imemaddr, instr_out, pc_out, npc_out, valid_out, halted
  );

  modport tb (
    output ihit, iload, stall, redirect_en, redirect_pc, halt_in,
    input  imemREN, imemaddr, instr_out, pc_out, npc_out, valid_out, halted
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a word fetched while decode was stalled.
module fetch_skid_buffer
  import my_types_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t entry_in,
  output fetch_entry_t entry_out,
  output logic         full
);
  fetch_entry_t entry_reg;
  logic         full_reg;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      entry_reg <= '0;
      full_reg  <= 1'b0;
    end else if (load) begin
      entry_reg <= entry_in;
      full_reg  <= 1'b1;
    end
  end

  assign entry_out = entry_reg;
  assign full      = full_reg;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues icache reads and fills the IF/ID register.
module fetch_stage
  import cpu_types_pkg::*;
  import my_types_pkg::*;
#(
  parameter word_t PC_INIT = PC_INIT_DEFAULT,
  parameter int    WORD_W  = 32
) (
  input logic       CLK,
  input logic       RST,
  fetch_stage_if.fs bus
);
  localparam word_t PC_STEP = WORD_W'(4);

  fetch_state_t state_reg, state_next;
  word_t        pc_reg, pc_next, pc_plus4;
  fetch_entry_t ifid_reg, ifid_next, hit_entry, skid_entry;
  logic         valid_reg, valid_next;
  logic         redirect_take, fetch_hit, skid_load, skid_clear, skid_full, drain;

  assign pc_plus4  = pc_reg + PC_STEP;
  assign hit_entry = '{instr: bus.iload, pc: pc_reg, npc: pc_plus4};

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= FS_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.halt_in || state_reg == FS_HALT) begin
      state_next = FS_HALT;
    end else if (bus.redirect_en) begin
      state_next = FS_RUN;
    end else begin
      case (state_reg)
        FS_RUN:  if (bus.ihit && bus.stall) state_next = FS_SKID;
        FS_SKID: if (!bus.stall)            state_next = FS_RUN;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    redirect_take = !bus.halt_in && state_reg != FS_HALT && bus.redirect_en;
    fetch_hit     = !bus.halt_in && !bus.redirect_en && state_reg == FS_RUN && bus.ihit;
    skid_load     = fetch_hit && bus.stall;
    drain         = !bus.halt_in && !bus.redirect_en && state_reg == FS_SKID
                    && !bus.stall && skid_full;
    // Draining also empties the buffer so the full flag tracks real occupancy.
    skid_clear    = bus.halt_in || redirect_take || drain;
  end

  assign bus.imemREN  = (state_reg == FS_RUN) && !RST;
  assign bus.imemaddr = pc_reg;
  assign bus.halted   = (state_reg == FS_HALT);

  always_comb begin
    pc_next    = pc_reg;
    ifid_next  = ifid_reg;
    valid_next = valid_reg;
    if (bus.halt_in) begin
      valid_next = 1'b0;
    end else if (state_reg == FS_HALT) begin
      valid_next = valid_reg;
    end else if (bus.redirect_en) begin
      pc_next    = bus.redirect_pc;
      valid_next = 1'b0;
    end else if (state_reg == FS_RUN) begin
      if (bus.ihit) pc_next = pc_plus4;
      if (!bus.stall) begin
        if (bus.ihit) ifid_next = hit_entry;
        valid_next = bus.ihit;
      end
    end else if (drain) begin
      ifid_next  = skid_entry;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg    <= PC_INIT;
      ifid_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      ifid_reg  <= ifid_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.instr_out = ifid_reg.instr;
  assign bus.pc_out    = ifid_reg.pc;
  assign bus.npc_out   = ifid_reg.npc;
  assign bus.valid_out = valid_reg;

  fetch_skid_buffer u_skid (
    .CLK      (CLK),
    .RST      (RST),
    .load     (skid_load),
    .clear    (skid_clear),
    .entry_in (hit_entry),
    .entry_out(skid_entry),
    .full     (skid_full)
  );
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode/control unit.
- Owns the PC and drives the icache request (imemREN/imemaddr). Accepts ihit/iload back from the icache.
- Registers the fetched word, with its PC and PC+4, into the IF/ID output. The control unit decodes from that output.
- Handles pipeline stall, branch/jump redirect and halt. A one-entry skid buffer prevents lost or duplicated instructions under stall.

Parameters:
- PC_INIT, 32'h0000_0000: PC value loaded on reset.
- WORD_W, 32: instruction and address width. Must equal the width of word_t.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  icache has valid data for imemaddr this cycle.
- iload  in  WORD_W  instruction word from the icache; valid when ihit=1.
- imemREN  out  1  icache read request.
- imemaddr  out  WORD_W  icache read address; equals the internal PC.
- stall  in  1  hazard unit: hold the IF/ID output this cycle.
- redirect_en  in  1  branch/jump/jr resolved taken; refetch from redirect_pc.
- redirect_pc  in  WORD_W  target address; word aligned.
- halt_in  in  1  halt instruction has retired; stop fetching.
- instr_out  out  WORD_W  registered instruction; the decode input.
- pc_out  out  WORD_W  PC of instr_out.
- npc_out  out  WORD_W  pc_out+4; used by jal and branch offset logic.
- valid_out  out  1  instr_out is a real instruction (0 = bubble).
- halted  out  1  stage has reached FS_HALT.

Behaviour:
- States: FS_RUN, FS_SKID, FS_HALT.
- Reset (RST=1 at an edge) values:
  - pc=PC_INIT; state=FS_RUN.
  - instr_out=0, pc_out=0, npc_out=0, valid_out=0.
  - skid buffer cleared; halted=0.
- RST overrides every other input in the same cycle. A reset mid-request drops the request; there is no memory of the prior ihit.
- Combinational outputs:
  - imemREN = (state==FS_RUN) && !RST.
  - imemaddr = pc.
  - halted = (state==FS_HALT).
- Priority at each edge: RST > halt_in > redirect_en > stall/ihit.
- halt_in=1, any state:
  - state goes to FS_HALT; valid_out<=0; skid cleared.
  - FS_HALT is exited only by RST. In FS_HALT, imemREN=0 and all other inputs are ignored.
- redirect_en=1, not halting, any non-halt state:
  - pc<=redirect_pc; state goes to FS_RUN.
  - valid_out<=0: the wrong-path IF/ID entry is squashed even if stall=1.
  - skid cleared; an ihit in the same cycle is discarded.
- FS_RUN, ihit=1, stall=0:
  - instr_out<=iload, pc_out<=pc, npc_out<=pc+4, valid_out<=1, pc<=pc+4.
  - Throughput is one instruction per cycle on back-to-back hits.
- FS_RUN, ihit=1, stall=1:
  - skid<={iload, pc, pc+4}; pc<=pc+4; state goes to FS_SKID.
  - IF/ID output held unchanged.
- FS_RUN, ihit=0, stall=0: valid_out<=0 (bubble inserted); other IF/ID fields hold; pc holds.
- FS_RUN, ihit=0, stall=1: everything holds.
- FS_SKID:
  - imemREN=0; ihit is ignored.
  - While stall=1: hold.
  - When stall=0: IF/ID<=skid with valid_out<=1; state goes to FS_RUN; fetch resumes at pc the next cycle.
- Arithmetic: pc+4 is modulo 2^WORD_W; 32'hFFFF_FFFC wraps to 0 with no flag.
- Latency:
  - The instruction is visible on instr_out the cycle after the ihit edge.
  - Redirect to first valid target instruction takes at least 2 cycles (1 bubble).
- No instruction is ever duplicated or lost across stall; only redirect or halt discards one.

Decomposition:
- Package: add fetch_state_t (FS_RUN, FS_SKID, FS_HALT) and a PC_INIT_DEFAULT constant to my_types_pkg.
- word_t comes from cpu_types_pkg.
- Add interface fetch_stage_if with modports fs (block side) and tb (bench side).
- One sub-module: fetch_skid_buffer. It is a one-entry register of {instr, pc, npc} with load, clear and a full flag, and is reset by RST.

Test Plan:
- Reset then continuous ihit=1, iload=32'h2001_0005: imemaddr steps 0,4,8, one per cycle; pc_out trails by one cycle; valid_out=1 from the first edge after reset deassert.
- ihit=1 at pc=8 with stall=1 for 3 cycles: IF/ID holds the pc=4 entry; state=FS_SKID; imemREN=0. On stall drop, instr_out holds the pc=8 word with npc_out=12, then fetch resumes at 12. No duplicate or gap.
- Miss: ihit=0 for 4 cycles at pc=0x10: valid_out=0 and imemaddr=0x10 throughout. ihit=1 then yields pc_out=0x10, valid_out=1.
- redirect_en=1, redirect_pc=0x40, with stall=1 and ihit=1 in the same cycle: next cycle imemaddr=0x40 and valid_out=0; the skid and the ihit data are discarded.
- halt_in=1 in FS_SKID together with redirect_en=1: state goes to FS_HALT, halted=1, imemREN=0, valid_out=0. RST then restores pc=PC_INIT and imemREN=1.
- Wrap: redirect_pc=32'hFFFF_FFFC, then ihit: npc_out=0 and the next imemaddr=0.
